// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, requester IDs
// and the default host burst limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_RD    = 2'd1,
        HOST_RD   = 2'd2,
        HOST_LOCK = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } req_e;

    localparam int HOST_MAX_BURST_DEF = 4;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-way tie breaker between CPU and host that remembers the last
// served requester. Optional macro ARB_RR_EN selects round-robin ties; otherwise CPU wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_cpu_req,
    input  logic i_host_req,
    input  logic i_update,
    input  req_e i_served,
    output logic o_grant_cpu,
    output logic o_grant_host
);

    req_e r_last_served;

    // Remember who completed last; HOST after reset so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_served <= REQ_HOST;
        end else if (i_update) begin
            r_last_served <= i_served;
        end else begin
            r_last_served <= r_last_served;
        end
    end

    // Single grant per cycle; only a tie consults the policy.
    always_comb begin
        o_grant_cpu  = 1'b0;
        o_grant_host = 1'b0;
        if (i_cpu_req && i_host_req) begin
`ifdef ARB_RR_EN
            o_grant_cpu  = (r_last_served == REQ_HOST);
            o_grant_host = (r_last_served == REQ_CPU);
`else
            o_grant_cpu  = 1'b1;
`endif
        end else begin
            o_grant_cpu  = i_cpu_req;
            o_grant_host = i_host_req;
        end
    end

`ifndef ARB_RR_EN
    // Fixed priority keeps the history register only for observability.
    logic w_unused_last;
    assign w_unused_last = r_last_served;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Data RAM arbiter between the CPU MEM stage and the host loader; sequences the
// 1-cycle read latency and drives StallM. Tie policy set by macro ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int HOST_MAX_BURST = HOST_MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReqM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_last,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(HOST_MAX_BURST + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_grant_cpu;
    logic             w_grant_host;
    logic             w_update;
    req_e             w_served;
    logic             w_cpu_wr_issue;
    logic             w_host_svc;
    logic             w_beat_done;

    rr_arbiter2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_cpu_req    (MemReqM),
        .i_host_req   (host_req),
        .i_update     (w_update),
        .i_served     (w_served),
        .o_grant_cpu  (w_grant_cpu),
        .o_grant_host (w_grant_host)
    );

    // State and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next state, RAM port muxing and handshakes; rst suppresses every issue and ack.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_count_inc    = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        w_update       = 1'b0;
        w_served       = REQ_HOST;
        w_cpu_wr_issue = 1'b0;
        w_host_svc     = 1'b0;
        w_beat_done    = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_we         = 1'b0;
        host_ack       = 1'b0;
        host_rdata     = '0;
        ReadDataM      = '0;
        if (rst) begin
            w_state_next = IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_cpu) begin
                        mem_addr = ALUOutM;
                        if (MemWriteM) begin
                            mem_we         = 1'b1;
                            mem_wdata      = WriteDataM;
                            w_cpu_wr_issue = 1'b1;
                            w_update       = 1'b1;
                            w_served       = REQ_CPU;
                        end else begin
                            w_state_next = CPU_RD;
                        end
                    end else begin
                        w_host_svc = w_grant_host;
                    end
                end
                CPU_RD: begin
                    ReadDataM    = mem_rdata;
                    w_update     = 1'b1;
                    w_served     = REQ_CPU;
                    w_state_next = IDLE;
                end
                HOST_RD: begin
                    host_ack    = 1'b1;
                    host_rdata  = mem_rdata;
                    w_beat_done = 1'b1;
                end
                HOST_LOCK: begin
                    if (host_req) begin
                        w_host_svc = 1'b1;
                    end else begin
                        w_count_next = '0;
                        w_update     = 1'b1;
                        w_served     = REQ_HOST;
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end
            endcase

            if (w_host_svc) begin
                mem_addr = host_addr;
                if (host_we) begin
                    mem_we      = 1'b1;
                    mem_wdata   = host_wdata;
                    host_ack    = 1'b1;
                    w_beat_done = 1'b1;
                end else begin
                    w_state_next = HOST_RD;
                end
            end else begin
                w_host_svc = 1'b0;
            end

            // A completed beat either closes the burst or keeps the exclusive grant.
            if (w_beat_done) begin
                if (host_last || (w_count_inc == CNT_W'(HOST_MAX_BURST))) begin
                    w_count_next = '0;
                    w_update     = 1'b1;
                    w_served     = REQ_HOST;
                    w_state_next = IDLE;
                end else begin
                    w_count_next = w_count_inc;
                    w_state_next = HOST_LOCK;
                end
            end else begin
                w_beat_done = 1'b0;
            end
        end
    end

    assign StallM = MemReqM & ~w_cpu_wr_issue & (r_state != CPU_RD) & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: IDLE decision table, then multi-cycle
// sequences scored against a reference memory through expected-data queues.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        StallM;
    logic        host_req, host_we, host_last, host_ack;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .HOST_MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
        .host_req(host_req), .host_we(host_we), .host_last(host_last),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM with one-cycle read latency
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ref_mem [0:255];
    logic [31:0] q_cpu[$];
    logic [31:0] q_host[$];
    int ack_cyc [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard monitor: checks issued stores and pops expected read data.
    always @(negedge clk) begin
        if (!rst) begin
            if (MemReqM && MemWriteM && !StallM) begin
                chk("cpu_store_we", mem_we, 1'b1);
                chk("cpu_store_addr", mem_addr, ALUOutM);
                chk("cpu_store_data", mem_wdata, WriteDataM);
            end
            if (MemReqM && !MemWriteM && !StallM) begin
                if (q_cpu.size() == 0) timeout_fail("cpu_read_unexpected");
                else chk("cpu_rdata", ReadDataM, q_cpu.pop_front());
            end
            if (host_ack && !host_we) begin
                if (q_host.size() == 0) timeout_fail("host_read_unexpected");
                else chk("host_rdata", host_rdata, q_host.pop_front());
            end
        end
    end

    task automatic clear_inputs();
        MemReqM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
        host_req = 1'b0; host_we = 1'b0; host_last = 1'b0;
        host_addr = '0; host_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [7:0] a, input logic [31:0] d,
                              output int served, output int stalls);
        MemReqM = 1'b1; MemWriteM = we; ALUOutM = {24'd0, a}; WriteDataM = d;
        if (we) ref_mem[a] = d;
        else q_cpu.push_back(ref_mem[a]);
        stalls = 0;
        @(negedge clk);
        while (StallM && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (StallM) timeout_fail("cpu_access");
        served = cyc;
        @(posedge clk);
        #1 MemReqM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic host_burst(input int n, input logic we, input logic [7:0] base, input logic set_last);
        int w;
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            host_req = 1'b1; host_we = we; host_addr = {24'd0, a};
            host_wdata = 32'hA000_0000 + 32'(i);
            host_last = set_last && (i == n - 1);
            if (we) ref_mem[a] = host_wdata;
            else q_host.push_back(ref_mem[a]);
            w = 0;
            @(negedge clk);
            while (!host_ack && w < 50) begin
                w++;
                @(negedge clk);
            end
            if (!host_ack) timeout_fail("host_beat");
            ack_cyc[i] = cyc;
            @(posedge clk);
            #1;
        end
        host_req = 1'b0; host_we = 1'b0; host_last = 1'b0;
    endtask

    typedef struct {
        string name;
        logic cr; logic cw; logic [31:0] ca; logic [31:0] cd;
        logic hr; logic hw; logic [31:0] ha; logic [31:0] hd;
        logic e_stall; logic e_ack; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, sc, st, n;
        tbl[0] = '{"idle_reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{"cpu_store", 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF};
        tbl[2] = '{"cpu_load", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h10, 32'h0};
        tbl[3] = '{"host_write", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234,
                   1'b0, 1'b1, 1'b1, 32'h20, 32'h1234};
        tbl[4] = '{"host_read", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h20, 32'h0};
        tbl[5] = '{"tie_load_hw", 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 32'h24, 32'h55,
                   1'b1, 1'b0, 1'b0, 32'h14, 32'h0};
        tbl[6] = '{"tie_store_hr", 1'b1, 1'b1, 32'h18, 32'h77, 1'b1, 1'b0, 32'h28, 32'h0,
                   1'b0, 1'b0, 1'b1, 32'h18, 32'h77};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            MemReqM = tbl[i].cr; MemWriteM = tbl[i].cw; ALUOutM = tbl[i].ca; WriteDataM = tbl[i].cd;
            host_req = tbl[i].hr; host_we = tbl[i].hw; host_addr = tbl[i].ha; host_wdata = tbl[i].hd;
            host_last = 1'b1;
            @(negedge clk);
            chk({tbl[i].name, "_stall"}, StallM, tbl[i].e_stall);
            chk({tbl[i].name, "_ack"}, host_ack, tbl[i].e_ack);
            chk({tbl[i].name, "_we"}, mem_we, tbl[i].e_we);
            chk({tbl[i].name, "_addr"}, mem_addr, tbl[i].e_addr);
            chk({tbl[i].name, "_wdata"}, mem_wdata, tbl[i].e_wdata);
            do_reset();
        end

        // Store then load of the same word
        cpu_access(1'b1, 8'h10, 32'hDEADBEEF, sc, st);
        chk("store_stalls", 64'(st), 64'd0);
        cpu_access(1'b0, 8'h10, 32'h0, sc, st);
        chk("load_stalls", 64'(st), 64'd1);

        // Six-beat host burst capped at four, CPU load slips in between
        t0 = cyc;
        fork
            host_burst(6, 1'b1, 8'h40, 1'b1);
            begin
                @(posedge clk);
                #1 cpu_access(1'b0, 8'h10, 32'h0, sc, st);
            end
        join
        for (int i = 0; i < 4; i++) chk("burst_ack_first4", 64'(ack_cyc[i] - t0), 64'(i));
        chk("burst_cpu_served", 64'(sc - t0), 64'd5);
        chk("burst_cpu_stalls", 64'(st), 64'd4);
        chk("burst_ack5", 64'(ack_cyc[4] - t0), 64'd6);
        chk("burst_ack6", 64'(ack_cyc[5] - t0), 64'd7);

        // Simultaneous CPU load and host read right after reset
        do_reset();
        t0 = cyc;
        fork
            cpu_access(1'b0, 8'h10, 32'h0, sc, st);
            host_burst(1, 1'b0, 8'h40, 1'b1);
        join
        chk("tie_cpu_first", 64'(sc - t0), 64'd1);
        chk("tie_host_ack", 64'(ack_cyc[0] - t0), 64'd3);

        // Continuous CPU stores against a pending host read
        do_reset();
        t0 = cyc;
        n = 0;
        fork
            begin
                MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h80; WriteDataM = 32'h1111;
                ref_mem[8'h80] = 32'h1111;
                repeat (10) begin
                    @(negedge clk);
                    if (host_ack) n++;
                end
                @(posedge clk);
                #1 MemReqM = 1'b0; MemWriteM = 1'b0;
            end
            host_burst(1, 1'b0, 8'h44, 1'b1);
        join
`ifdef ARB_RR_EN
        chk("rr_host_acks_during", 64'(n), 64'd1);
        chk("rr_host_ack_cycle", 64'(ack_cyc[0] - t0), 64'd2);
`else
        chk("fixed_host_starved", 64'(n), 64'd0);
        chk("fixed_host_ack_cycle", 64'(ack_cyc[0] - t0), 64'd11);
`endif

        // Host abandons its burst after two beats; pending store then issues
        do_reset();
        t0 = cyc;
        fork
            host_burst(2, 1'b1, 8'h50, 1'b0);
            begin
                @(posedge clk);
                #1 cpu_access(1'b1, 8'h60, 32'h6060, sc, st);
            end
        join
        chk("drop_ack2", 64'(ack_cyc[1] - t0), 64'd1);
        chk("drop_store_cycle", 64'(sc - t0), 64'd3);
        chk("drop_store_stalls", 64'(st), 64'd2);
        // Counter was cleared: a new burst still gets four full beats
        t1 = cyc;
        fork
            host_burst(5, 1'b1, 8'h70, 1'b0);
            begin
                @(posedge clk);
                #1 cpu_access(1'b1, 8'h64, 32'h6464, sc, st);
            end
        join
        chk("recount_ack4", 64'(ack_cyc[3] - t1), 64'd3);
        chk("recount_store", 64'(sc - t1), 64'd4);
        chk("recount_ack5", 64'(ack_cyc[4] - t1), 64'd5);

        // Reset while a host read is in flight
        do_reset();
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40; host_last = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_hostrd_no_ack", host_ack, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk("rst_stall", StallM, 1'b0);
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdatam", ReadDataM, 32'h0);
        chk("rst_host_rdata", host_rdata, 32'h0);
        @(negedge clk);
        chk("rst_no_late_ack", host_ack, 1'b0);

        chk("cpu_queue_drained", 64'(q_cpu.size()), 64'd0);
        chk("host_queue_drained", 64'(q_host.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Data-memory port arbiter for the pipelined CPU. It shares the single synchronous data RAM between the MEM stage (loads/stores) and an external host loader (key/message load and result readback). It sequences each access, including the 1-cycle RAM read latency, and drives the stall that freezes the pipeline segment registers while the MEM stage waits.

## Interface
- ADDR_W, 32, RAM address width
- DATA_W, 32, data width
- HOST_MAX_BURST, 4, max host beats per grant before forced release (≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- MemReqM  in  1  MEM stage requests access (load or store)
- MemWriteM  in  1  1 = store, 0 = load
- ALUOutM  in  ADDR_W  MEM-stage address
- WriteDataM  in  DATA_W  store data
- ReadDataM  out  DATA_W  load data, valid in CPU_RD cycle
- StallM  out  1  freeze IF..MEM segment registers
- host_req  in  1  host request, held with operands until host_ack
- host_we  in  1  host write
- host_last  in  1  final beat of host burst
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle beat completion pulse
- host_rdata  out  DATA_W  host read data, valid with host_ack on reads
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, one cycle after address

## Operation
- States: IDLE, CPU_RD, HOST_RD, HOST_LOCK.
- IDLE: grant decided combinationally among MemReqM and host_req. Only one requester is granted per cycle.
  - CPU write granted: mem_we=1 this cycle, StallM=0, stay IDLE.
  - CPU read granted: drive address, go CPU_RD.
  - Host write granted: mem_we=1, host_ack=1 this cycle.
  - Host read granted: drive address, go HOST_RD.
- CPU_RD: ReadDataM=mem_rdata, StallM=0, last_served←CPU, next IDLE. No new issue this cycle.
- HOST_RD: host_ack=1, host_rdata=mem_rdata. No new issue this cycle.
- After each acked host beat, increment beat count.
  - If host_last or count==HOST_MAX_BURST: last_served←HOST, clear count, next IDLE.
  - Otherwise: next HOST_LOCK.
- HOST_LOCK: host has exclusive grant and is serviced as in IDLE; CPU is not considered. If host_req=0, abandon the burst: clear count, last_served←HOST, next IDLE.
- StallM = MemReqM & ~(CPU write issued this cycle) & (state≠CPU_RD).
  - Stalls for the whole of a host beat/burst.
  - Stalls for the address cycle of a CPU load.
- mem_addr/mem_wdata/mem_we are combinational from the granted requester. mem_we=0 whenever no write is issued. mem_addr/mem_wdata are don't-care when idle but driven to 0.
- Beat counter width $clog2(HOST_MAX_BURST+1). It never exceeds HOST_MAX_BURST.

## Timing
- Reset values: state=IDLE, count=0, last_served=HOST (so the CPU wins the first tie), StallM=0, host_ack=0, mem_we=0, ReadDataM=0, host_rdata=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: any in-flight read is dropped with no ack. The burst is terminated. Outputs take reset values in the cycle after rst is sampled high.
- Latency, uncontended:
  - CPU store: 0 stall cycles.
  - CPU load: 1 stall cycle.
  - Host write: ack in the request cycle.
  - Host read: ack 1 cycle after the request cycle.
- Host must hold req/we/addr/wdata/last stable until host_ack. It may drop req only after ack. Dropping req mid-burst in HOST_LOCK is legal and releases the grant.
- MemReqM and operands are held by the stalled pipeline while StallM=1.
- Simultaneous requests in IDLE are resolved per Configuration.

## Configuration
- ARB_RR_EN defined: a tie in IDLE is granted to the requester that is not last_served (round-robin). Each requester waits at most one host burst or one CPU access.
- ARB_RR_EN undefined: a tie always goes to the CPU (fixed priority). last_served is still maintained but ignored. The host can starve under continuous MemReqM.

## Structure
- Package mem_arb_pkg: state enum (IDLE, CPU_RD, HOST_RD, HOST_LOCK), requester enum (REQ_CPU, REQ_HOST), default HOST_MAX_BURST constant.
- Sub-module rr_arbiter2: 2-way tie breaker holding last_served, with the ARB_RR_EN-controlled policy. The top level holds the FSM, beat counter and muxes.

## Test plan
- CPU store 0x10←0xDEADBEEF with no host activity -> mem_we=1 same cycle, StallM=0; later load of 0x10 -> StallM=1 for 1 cycle, ReadDataM=0xDEADBEEF next cycle.
- Host burst of 6 writes (host_last on beat 6), HOST_MAX_BURST=4, with a CPU load pending -> 4 acks, IDLE, CPU load served (round-robin), then remaining 2 host beats.
- CPU load and host read in the same cycle right after reset, ARB_RR_EN defined -> CPU granted first, host_ack with host_rdata 2 cycles later.
- Same as above with ARB_RR_EN undefined and MemReqM held high for 10 cycles -> host_ack never asserts during those cycles.
- Host drops host_req in HOST_LOCK after 2 beats -> next cycle IDLE, count=0, pending CPU store issues with StallM=0.
- rst asserted in HOST_RD -> no host_ack; next cycle state IDLE and all outputs at reset values.
